// File: rtl/program_loader.sv
// Boot loader that receives a length-prefixed program over a byte link, writes it
// to program memory as halfwords and holds the CPU in reset until the load completes.
module program_loader #(
  parameter int MAX_HALFWORDS  = 1024,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        program_mem_write_en_o,
  output logic [15:0] instruction_o,
  output logic [31:0] instruction_addr_o,
  output logic        cpu_reset_o,
  output logic        load_done_o,
  output logic        error_o
);

  // state   | meaning
  // LEN_LO  | waiting for length low byte (no timeout)
  // LEN_HI  | waiting for length high byte
  // DATA_LO | waiting for halfword low byte
  // DATA_HI | waiting for halfword high byte; write issued next cycle
  // DONE    | program loaded, CPU released
  // ERROR   | load aborted (oversize frame or link timeout)
  typedef enum logic [2:0] {
    LEN_LO  = 3'd0,
    LEN_HI  = 3'd1,
    DATA_LO = 3'd2,
    DATA_HI = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  state_t        state, state_next;
  logic [7:0]    len_lo;
  logic [7:0]    lo_byte;
  logic [15:0]   len;
  logic [15:0]   hw_count;
  logic [31:0]   write_addr;
  logic [TW-1:0] idle_cnt;
  logic [15:0]   frame_len;
  logic          timed;
  logic          timeout;
  logic          last_hw;

  always_comb begin
    frame_len = {byte_i, len_lo};
    timed     = (state == LEN_HI) || (state == DATA_LO) || (state == DATA_HI);
    // A byte in the terminal idle cycle wins over the timeout.
    timeout   = timed && !byte_valid_i && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    last_hw   = ({1'b0, hw_count} + 17'd1) == {1'b0, len};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= LEN_LO;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cpu_reset_o = 1'b1;
    load_done_o = 1'b0;
    error_o     = 1'b0;
    case (state)
      LEN_LO: begin
        if (byte_valid_i) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (byte_valid_i) begin
          if (frame_len == 16'd0)                   state_next = DONE;
          else if (32'(frame_len) > MAX_HALFWORDS) state_next = ERROR;
          else                                      state_next = DATA_LO;
        end else if (timeout) begin
          state_next = ERROR;
        end
      end
      DATA_LO: begin
        if (byte_valid_i) state_next = DATA_HI;
        else if (timeout) state_next = ERROR;
      end
      DATA_HI: begin
        if (byte_valid_i) state_next = last_hw ? DONE : DATA_LO;
        else if (timeout) state_next = ERROR;
      end
      DONE: begin
        cpu_reset_o = 1'b0;
        load_done_o = 1'b1;
      end
      ERROR: begin
        error_o = 1'b1;
      end
      default: state_next = LEN_LO;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      len_lo                 <= 8'd0;
      lo_byte                <= 8'd0;
      len                    <= 16'd0;
      hw_count               <= 16'd0;
      write_addr             <= 32'd0;
      idle_cnt               <= '0;
      program_mem_write_en_o <= 1'b0;
      instruction_o          <= 16'd0;
      instruction_addr_o     <= 32'd0;
    end else begin
      program_mem_write_en_o <= 1'b0;
      if (byte_valid_i && state == LEN_LO)  len_lo  <= byte_i;
      if (byte_valid_i && state == LEN_HI)  len     <= frame_len;
      if (byte_valid_i && state == DATA_LO) lo_byte <= byte_i;
      // Data and address are registered together with the strobe so they are
      // stable for the whole write cycle even if the next low byte arrives then.
      if (byte_valid_i && state == DATA_HI) begin
        program_mem_write_en_o <= 1'b1;
        instruction_o          <= {byte_i, lo_byte};
        instruction_addr_o     <= write_addr;
        write_addr             <= write_addr + 32'd2;
        hw_count               <= hw_count + 16'd1;
      end
      if (byte_valid_i || !timed || state_next != state) idle_cnt <= '0;
      else                                               idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frame loads, length limits, link timeout,
// mid-load reset and byte rejection after completion.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_d = 8'h00;
  logic        we;
  logic [15:0] instr;
  logic [31:0] addr;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic prev_we = 1'b0;

  program_loader #(.MAX_HALFWORDS(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_i                  (clk),
    .reset_i                (rst),
    .byte_valid_i           (byte_valid),
    .byte_i                 (byte_d),
    .program_mem_write_en_o (we),
    .instruction_o          (instr),
    .instruction_addr_o     (addr),
    .cpu_reset_o            (cpu_rst),
    .load_done_o            (done),
    .error_o                (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) begin
      n_writes++;
      n_checks++;
      if (prev_we) begin
        $display("FAIL strobe_back_to_back: got two consecutive write strobes, expected at most one");
        n_fail++;
      end
    end
    prev_we = we;
  end

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_d     = b;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_writes = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_writes = 0;
    if (we !== 1'b0)       begin $display("FAIL reset_we: got %0b expected 0", we); n_fail++; end
    n_checks++;
    if (instr !== 16'h0)   begin $display("FAIL reset_instr: got %h expected 0000", instr); n_fail++; end
    n_checks++;
    if (addr !== 32'h0)    begin $display("FAIL reset_addr: got %h expected 00000000", addr); n_fail++; end
    n_checks++;
    if (cpu_rst !== 1'b1)  begin $display("FAIL reset_cpu_reset: got %0b expected 1", cpu_rst); n_fail++; end
    n_checks++;
    if (done !== 1'b0)     begin $display("FAIL reset_done: got %0b expected 0", done); n_fail++; end
    n_checks++;
    if (err !== 1'b0)      begin $display("FAIL reset_error: got %0b expected 0", err); n_fail++; end
    n_checks++;
  endtask

  task automatic test_two_halfwords;
    pulse_reset();
    send(8'h02); send(8'h00); send(8'h34); send(8'h12);
    if (we !== 1'b1)         begin $display("FAIL two_hw_we0: got %0b expected 1", we); n_fail++; end
    n_checks++;
    if (instr !== 16'h1234)  begin $display("FAIL two_hw_instr0: got %h expected 1234", instr); n_fail++; end
    n_checks++;
    if (addr !== 32'h0)      begin $display("FAIL two_hw_addr0: got %h expected 00000000", addr); n_fail++; end
    n_checks++;
    if (done !== 1'b0)       begin $display("FAIL two_hw_done_early: got %0b expected 0", done); n_fail++; end
    n_checks++;
    send(8'h78);
    if (we !== 1'b0)         begin $display("FAIL two_hw_we_gap: got %0b expected 0", we); n_fail++; end
    n_checks++;
    send(8'h56);
    if (we !== 1'b1)         begin $display("FAIL two_hw_we1: got %0b expected 1", we); n_fail++; end
    n_checks++;
    if (instr !== 16'h5678)  begin $display("FAIL two_hw_instr1: got %h expected 5678", instr); n_fail++; end
    n_checks++;
    if (addr !== 32'h2)      begin $display("FAIL two_hw_addr1: got %h expected 00000002", addr); n_fail++; end
    n_checks++;
    idle(1);
    if (we !== 1'b0)         begin $display("FAIL two_hw_we_end: got %0b expected 0", we); n_fail++; end
    n_checks++;
    if (done !== 1'b1)       begin $display("FAIL two_hw_done: got %0b expected 1", done); n_fail++; end
    n_checks++;
    if (cpu_rst !== 1'b0)    begin $display("FAIL two_hw_cpu_reset: got %0b expected 0", cpu_rst); n_fail++; end
    n_checks++;
    if (n_writes !== 2)      begin $display("FAIL two_hw_count: got %0d expected 2", n_writes); n_fail++; end
    n_checks++;
  endtask

  task automatic test_zero_length;
    pulse_reset();
    send(8'h00); send(8'h00);
    if (done !== 1'b1)       begin $display("FAIL zero_len_done: got %0b expected 1", done); n_fail++; end
    n_checks++;
    if (cpu_rst !== 1'b0)    begin $display("FAIL zero_len_cpu_reset: got %0b expected 0", cpu_rst); n_fail++; end
    n_checks++;
    idle(2);
    if (n_writes !== 0)      begin $display("FAIL zero_len_writes: got %0d expected 0", n_writes); n_fail++; end
    n_checks++;
  endtask

  task automatic test_max_length;
    pulse_reset();
    send(8'h04); send(8'h00);
    for (int i = 1; i <= 4; i++) begin
      send(8'(i)); send(8'h00);
    end
    if (instr !== 16'h0004)  begin $display("FAIL max_len_instr: got %h expected 0004", instr); n_fail++; end
    n_checks++;
    if (addr !== 32'h6)      begin $display("FAIL max_len_addr: got %h expected 00000006", addr); n_fail++; end
    n_checks++;
    if (done !== 1'b1)       begin $display("FAIL max_len_done: got %0b expected 1", done); n_fail++; end
    n_checks++;
    idle(1);
    if (n_writes !== 4)      begin $display("FAIL max_len_writes: got %0d expected 4", n_writes); n_fail++; end
    n_checks++;
  endtask

  task automatic test_oversize;
    pulse_reset();
    send(8'h05); send(8'h00);
    if (err !== 1'b1)        begin $display("FAIL oversize_error: got %0b expected 1", err); n_fail++; end
    n_checks++;
    if (cpu_rst !== 1'b1)    begin $display("FAIL oversize_cpu_reset: got %0b expected 1", cpu_rst); n_fail++; end
    n_checks++;
    send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    idle(1);
    if (n_writes !== 0)      begin $display("FAIL oversize_writes: got %0d expected 0", n_writes); n_fail++; end
    n_checks++;
    if (err !== 1'b1 || done !== 1'b0)
                             begin $display("FAIL oversize_sticky: got err=%0b done=%0b expected err=1 done=0", err, done); n_fail++; end
    n_checks++;
  endtask

  task automatic test_timeout;
    pulse_reset();
    idle(40);
    if (err !== 1'b0)        begin $display("FAIL len_lo_no_timeout: got %0b expected 0", err); n_fail++; end
    n_checks++;
    send(8'h01);
    idle(16);
    if (err !== 1'b1)        begin $display("FAIL len_hi_timeout: got %0b expected 1", err); n_fail++; end
    n_checks++;
    pulse_reset();
    send(8'h01); send(8'h00); send(8'hAA);
    idle(15);
    if (err !== 1'b0)        begin $display("FAIL data_timeout_early: got %0b expected 0", err); n_fail++; end
    n_checks++;
    idle(1);
    if (err !== 1'b1)        begin $display("FAIL data_timeout: got %0b expected 1", err); n_fail++; end
    n_checks++;
    idle(1);
    if (n_writes !== 0)      begin $display("FAIL data_timeout_writes: got %0d expected 0", n_writes); n_fail++; end
    n_checks++;
    pulse_reset();
    send(8'h01); send(8'h00); send(8'hAA);
    idle(15);
    send(8'hBB);
    if (we !== 1'b1)         begin $display("FAIL last_cycle_byte_we: got %0b expected 1", we); n_fail++; end
    n_checks++;
    if (instr !== 16'hBBAA)  begin $display("FAIL last_cycle_byte_instr: got %h expected bbaa", instr); n_fail++; end
    n_checks++;
    if (err !== 1'b0 || done !== 1'b1)
                             begin $display("FAIL last_cycle_byte_state: got err=%0b done=%0b expected err=0 done=1", err, done); n_fail++; end
    n_checks++;
  endtask

  task automatic test_reset_midload;
    pulse_reset();
    send(8'h02); send(8'h00); send(8'h11);
    byte_valid = 1'b1;
    byte_d     = 8'h22;
    rst        = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
    rst        = 1'b0;
    if (we !== 1'b0)         begin $display("FAIL midload_strobe_suppressed: got %0b expected 0", we); n_fail++; end
    n_checks++;
    idle(1);
    if (n_writes !== 0)      begin $display("FAIL midload_writes: got %0d expected 0", n_writes); n_fail++; end
    n_checks++;
    send(8'h01); send(8'h00); send(8'hCD); send(8'hAB);
    if (we !== 1'b1)         begin $display("FAIL midload_we: got %0b expected 1", we); n_fail++; end
    n_checks++;
    if (instr !== 16'hABCD)  begin $display("FAIL midload_instr: got %h expected abcd", instr); n_fail++; end
    n_checks++;
    if (addr !== 32'h0)      begin $display("FAIL midload_addr: got %h expected 00000000", addr); n_fail++; end
    n_checks++;
    if (done !== 1'b1)       begin $display("FAIL midload_done: got %0b expected 1", done); n_fail++; end
    n_checks++;
    idle(1);
    if (n_writes !== 1)      begin $display("FAIL midload_count: got %0d expected 1", n_writes); n_fail++; end
    n_checks++;
  endtask

  task automatic test_after_done;
    send(8'hFF); send(8'hFF); send(8'hFF);
    idle(2);
    if (n_writes !== 1)      begin $display("FAIL after_done_writes: got %0d expected 1", n_writes); n_fail++; end
    n_checks++;
    if (addr !== 32'h0)      begin $display("FAIL after_done_addr: got %h expected 00000000", addr); n_fail++; end
    n_checks++;
    if (instr !== 16'hABCD)  begin $display("FAIL after_done_instr: got %h expected abcd", instr); n_fail++; end
    n_checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0)
                             begin $display("FAIL after_done_state: got done=%0b cpu_reset=%0b expected done=1 cpu_reset=0", done, cpu_rst); n_fail++; end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_two_halfwords();
    test_zero_length();
    test_max_length();
    test_oversize();
    test_timeout();
    test_reset_midload();
    test_after_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
